fifo_write_arbiter: RTL and testbench

Write-side arbiter and burst sequencer for the asynchronous FIFO. It shares the single FIFO write port between `NUM_REQ` requesters in round-robin order, granting each winner a burst of 1..`MAX_BURST` words. It drives `WriteEn`/`WriteData` into the FIFO write domain and stalls on the `Full` flag produced by the flag-control logic. Single clock domain: `write_clk`.

---
 rtl/fifo_write_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Write-side arbiter for the async FIFO: shares the single write port among
// NUM_REQ requesters in round-robin order, one burst of 1..2^BURST_WIDTH words
// per grant, and stalls while the FIFO reports Full.
module fifo_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_WIDTH = 3
) (
    input  logic                              write_clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*BURST_WIDTH-1:0]    req_len,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
    input  logic                              Full,
    output logic [NUM_REQ-1:0]                grant,
    output logic [NUM_REQ-1:0]                data_ack,
    output logic                              WriteEn,
    output logic [DATA_WIDTH-1:0]             WriteData,
    output logic                              busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state, state_nxt;
    logic [NUM_REQ-1:0]     grant_nxt;
    logic [IDX_W-1:0]       last_grant, last_grant_nxt;
    logic [BURST_WIDTH-1:0] remain, remain_nxt;

    logic [IDX_W-1:0]       winner;
    logic                   win_vld;
    logic                   owner_req;

    // Unpack the flat per-requester buses so they can be indexed by requester id.
    logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];
    logic [BURST_WIDTH-1:0] len_arr  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign len_arr[i]  = req_len[i*BURST_WIDTH +: BURST_WIDTH];
    end

    // Round-robin search starting just above the last winner. The loop runs
    // from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        int idx;
        idx     = 0;
        winner  = '0;
        win_vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (req[idx]) begin
                winner  = IDX_W'(idx);
                win_vld = 1'b1;
            end
        end
    end

    // The burst owner is always last_grant while in BURST.
    assign owner_req = req[last_grant];
    assign busy      = (state == BURST);

    // Next-state and write-port outputs. Reset blocks the write in the same
    // cycle so a word acked while rst is high is never handed to the FIFO.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        remain_nxt     = remain;
        WriteEn        = 1'b0;
        WriteData      = '0;
        data_ack       = '0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt         = BURST;
                    grant_nxt         = '0;
                    grant_nxt[winner] = 1'b1;
                    last_grant_nxt    = winner;
                    remain_nxt        = len_arr[winner];
                end
            end
            BURST: begin
                WriteEn   = owner_req & ~Full & ~rst;
                WriteData = data_arr[last_grant];
                data_ack  = grant & {NUM_REQ{WriteEn}};
                if (!owner_req) begin
                    // Owner withdrew: abort, nothing written this cycle.
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end else if (!Full) begin
                    if (remain == '0) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end else begin
                        remain_nxt = remain - 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // State registers; reset leaves requester 0 with top priority.
    always_ff @(posedge write_clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            remain     <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            remain     <= remain_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: a transaction-level model (owner id, words
// left, last winner) predicts every output each cycle; directed scenarios add
// literal expectations on grant order and write counts.
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*BW-1:0]  req_len;
    logic [NR*DW-1:0]  req_data;
    logic              Full;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     data_ack;
    logic              WriteEn;
    logic [DW-1:0]     WriteData;
    logic              busy;

    fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
        .write_clk(clk), .rst(rst), .req(req), .req_len(req_len),
        .req_data(req_data), .Full(Full), .grant(grant), .data_ack(data_ack),
        .WriteEn(WriteEn), .WriteData(WriteData), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    // Observations of the DUT used by the directed checks.
    logic [NR-1:0] grant_log[$];
    int            wr_count   = 0;
    int            busy_count = 0;
    logic          prev_busy  = 1'b0;

    // Model state: owner = -1 means no burst in progress.
    int m_owner = -1;
    int m_left  = 0;
    int m_last  = NR - 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare and advance the model mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        logic          e_busy, e_we;
        logic [NR-1:0] e_grant, e_ack;
        logic [DW-1:0] e_wd;
        e_busy  = (m_owner >= 0);
        e_grant = '0;
        e_wd    = '0;
        e_we    = 1'b0;
        if (e_busy) begin
            e_grant[m_owner] = 1'b1;
            e_wd             = req_data[m_owner*DW +: DW];
            e_we             = req[m_owner] && !Full && !rst;
        end
        e_ack = e_we ? e_grant : '0;
        if (chk_en) begin
            check("busy", 64'(busy), 64'(e_busy));
            check("grant", 64'(grant), 64'(e_grant));
            check("WriteEn", 64'(WriteEn), 64'(e_we));
            check("WriteData", 64'(WriteData), 64'(e_wd));
            check("data_ack", 64'(data_ack), 64'(e_ack));
        end
        if (busy && !prev_busy) grant_log.push_back(grant);
        prev_busy = busy;
        if (WriteEn) wr_count++;
        if (busy) busy_count++;
        // Model transition for the coming edge.
        if (rst) begin
            m_owner = -1;
            m_last  = NR - 1;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (m_last + k) % NR;
                if (req[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_left  = int'(req_len[c*BW +: BW]) + 1;
                    break;
                end
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end else if (e_we) begin
            m_left--;
            if (m_left == 0) m_owner = -1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        grant_log.delete();
        wr_count   = 0;
        busy_count = 0;
    endtask

    task automatic check_log(input string nm, input logic [NR-1:0] exp[$]);
        check({nm, "_len"}, 64'(grant_log.size()), 64'(exp.size()));
        foreach (exp[i])
            if (i < grant_log.size()) check(nm, 64'(grant_log[i]), 64'(exp[i]));
    endtask

    initial begin
        rst = 1'b1; req = '0; req_len = '0; req_data = '0; Full = 1'b0;
        tick(2);
        chk_en = 1'b1;
        rst = 1'b0;
        // Reset state.
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_we", 64'(WriteEn), 64'h0);
        check("rst_wd", 64'(WriteData), 64'h0);

        // Reset priority: 0,1,2,3,0 with single-word bursts.
        clear_obs();
        req = 4'b1111; req_len = '0; req_data = 32'h44332211;
        tick(10);
        req = '0;
        tick(2);
        check_log("rr_order", '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001});
        check("rr_writes", 64'(wr_count), 64'd5);

        // Max-length burst from requester 2 with changing data.
        clear_obs();
        req = 4'b0100; req_len = 12'(7) << (2*BW);
        for (int i = 0; i < 9; i++) begin
            req_data = $urandom;
            tick(1);
        end
        req = '0;
        tick(2);
        check_log("burst8_grant", '{4'b0100});
        check("burst8_writes", 64'(wr_count), 64'd8);
        check("burst8_cycles", 64'(busy_count), 64'd8);
        check("burst8_busy_end", 64'(busy), 64'h0);

        // Full stall: 4-word burst, Full for 3 cycles after word 2.
        clear_obs();
        req = 4'b0001; req_len = 12'(3); req_data = $urandom;
        tick(3);
        Full = 1'b1;
        tick(3);
        Full = 1'b0;
        tick(2);
        req = '0;
        tick(2);
        check("stall_writes", 64'(wr_count), 64'd4);
        check("stall_cycles", 64'(busy_count), 64'd7);
        check_log("stall_grant", '{4'b0001});

        // Abort: requester 1 withdraws after two words; search resumes at 2.
        clear_obs();
        req = 4'b0010; req_len = 12'(5) << BW; req_data = $urandom;
        tick(3);
        req = 4'b1101;
        tick(3);
        req = '0;
        tick(2);
        check("abort_writes", 64'(wr_count), 64'd3);
        check_log("abort_order", '{4'b0010, 4'b0100});

        // Reset during word 3 of 6; afterwards requester 1 wins over 3.
        clear_obs();
        req = 4'b0001; req_len = 12'(5); req_data = $urandom;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0; req = 4'b1010; req_len = '0;
        check("mid_rst_grant", 64'(grant), 64'h0);
        check("mid_rst_busy", 64'(busy), 64'h0);
        check("mid_rst_ack", 64'(data_ack), 64'h0);
        tick(2);
        req = '0;
        tick(2);
        check("mid_rst_writes", 64'(wr_count), 64'd3);
        check_log("mid_rst_order", '{4'b0001, 4'b0010});

        // Contention: 0 and 3 alternate; 1 joins during a burst of 0.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        clear_obs();
        req = 4'b1001; req_len = {4{3'd1}}; req_data = $urandom;
        tick(13);
        req = 4'b1011;
        tick(8);
        req = '0;
        tick(2);
        check_log("fair_order", '{4'b0001, 4'b1000, 4'b0001, 4'b1000,
                                  4'b0001, 4'b0010, 4'b1000});
        check("fair_writes", 64'(wr_count), 64'd14);

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NR; i++)
                if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
            Full     = ($urandom_range(0, 3) == 0);
            req_len  = 12'($urandom);
            req_data = $urandom;
            tick(1);
        end
        rst = 1'b0; req = '0; Full = 1'b0;
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
